// File: rtl/cart_upload_reader_if.sv
// cart_upload_reader_if: HPS upload handshake plus SDRAM channel-0 read port for the cart read-back path.
interface cart_upload_reader_if #(
    parameter int ADDR_W = 19
);
    logic              ioctl_upload;
    logic              ioctl_rd;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_din;
    logic              ioctl_wait;
    logic [ADDR_W-1:0] rom_mask;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_busy;
    logic [7:0]        mem_dout;
    logic              active;
    logic              timeout_err;

    modport slave (
        input  ioctl_upload,
        input  ioctl_rd,
        input  ioctl_addr,
        input  rom_mask,
        input  mem_busy,
        input  mem_dout,
        output ioctl_din,
        output ioctl_wait,
        output mem_addr,
        output mem_rd,
        output active,
        output timeout_err
    );

    modport master (
        output ioctl_upload,
        output ioctl_rd,
        output ioctl_addr,
        output rom_mask,
        output mem_busy,
        output mem_dout,
        input  ioctl_din,
        input  ioctl_wait,
        input  mem_addr,
        input  mem_rd,
        input  active,
        input  timeout_err
    );
endinterface

// File: rtl/cart_upload_reader.sv
// cart_upload_reader: serves HPS upload byte reads from SDRAM channel 0 with a one-byte sequential prefetch.
module cart_upload_reader #(
    parameter int ADDR_W  = 19,
    parameter int TIMEOUT = 255
) (
    input logic                  clk_sys,
    input logic                  reset,
    cart_upload_reader_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DELIVER, PREFETCH} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_active;
    logic              r_wait;
    logic              r_err;
    logic [7:0]        r_din;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_is_pf;
    logic              r_first;
    logic [CW-1:0]     r_cnt;
    logic              r_pf_valid;
    logic [ADDR_W-1:0] r_pf_addr;
    logic [7:0]        r_pf_data;
    logic              r_pend;
    logic [ADDR_W-1:0] r_pend_addr;

    logic              w_abort;
    logic              w_req;
    logic              w_oob;
    logic              w_hit;
    logic              w_take;
    logic              w_done;
    logic              w_tmo;
    logic              w_pf_ok;
    logic [ADDR_W-1:0] w_a;
    logic [ADDR_W-1:0] w_inc;
    logic              w_unused;

    assign w_unused = ^bus.ioctl_addr[24:ADDR_W];
    assign w_abort  = !bus.ioctl_upload;
    // a request held during a prefetch takes priority over the live strobe
    assign w_a      = r_pend ? r_pend_addr : bus.ioctl_addr[ADDR_W-1:0];
    assign w_req    = r_active && (r_pend || (bus.ioctl_rd && !r_wait));
    assign w_oob    = w_a > bus.rom_mask;
    assign w_hit    = r_pf_valid && r_pf_addr == w_a;
    assign w_take   = r_active && bus.ioctl_rd && !r_wait && !r_pend && r_state != IDLE;
    assign w_done   = !r_first && !bus.mem_busy;
    assign w_tmo    = r_cnt == CW'(TIMEOUT);
    assign w_inc    = r_addr + ADDR_W'(1);
    assign w_pf_ok  = w_inc != '0 && w_inc <= bus.rom_mask;

    assign bus.ioctl_din   = r_din;
    assign bus.ioctl_wait  = r_wait;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.active      = r_active;
    assign bus.timeout_err = r_err;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = w_abort               ? IDLE :
                 r_state == IDLE       ? (w_req && !w_oob ? (w_hit ? PREFETCH : ISSUE) : IDLE) :
                 r_state == ISSUE      ? WAIT :
                 r_state == WAIT       ? (w_done ? (r_is_pf ? IDLE : DELIVER) : (w_tmo ? IDLE : WAIT)) :
                 r_state == DELIVER    ? PREFETCH :
                 (w_pf_ok ? ISSUE : IDLE);
    end

    // gated by the live level so no request leaves on the cycle the session ends
    always_comb begin
        bus.mem_rd = r_state == ISSUE && bus.ioctl_upload;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_active    <= 1'b0;
            r_wait      <= 1'b0;
            r_err       <= 1'b0;
            r_din       <= 8'hFF;
            r_mem_addr  <= '0;
            r_addr      <= '0;
            r_is_pf     <= 1'b0;
            r_first     <= 1'b0;
            r_cnt       <= '0;
            r_pf_valid  <= 1'b0;
            r_pf_addr   <= '0;
            r_pf_data   <= 8'h00;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
        end else begin
            r_active <= bus.ioctl_upload;
            if (w_abort) begin
                r_wait     <= 1'b0;
                r_pf_valid <= 1'b0;
                r_pend     <= 1'b0;
            end else begin
                if (!r_active) begin
                    r_err      <= 1'b0;
                    r_pf_valid <= 1'b0;
                end
                if (w_take) begin
                    r_pend      <= 1'b1;
                    r_pend_addr <= bus.ioctl_addr[ADDR_W-1:0];
                    r_wait      <= 1'b1;
                end
                case (r_state)
                    IDLE: if (w_req) begin
                        r_pend <= 1'b0;
                        r_addr <= w_a;
                        if (w_oob) begin
                            r_din  <= 8'hFF;
                            r_wait <= 1'b0;
                        end else if (w_hit) begin
                            r_din  <= r_pf_data;
                            r_wait <= 1'b0;
                        end else begin
                            r_wait     <= 1'b1;
                            r_mem_addr <= w_a;
                            r_is_pf    <= 1'b0;
                        end
                    end
                    ISSUE: begin
                        r_cnt   <= CW'(1);
                        r_first <= 1'b1;
                    end
                    WAIT: begin
                        r_cnt   <= r_cnt + CW'(1);
                        r_first <= 1'b0;
                        if (w_done) begin
                            if (r_is_pf) begin
                                r_pf_data  <= bus.mem_dout;
                                r_pf_addr  <= r_mem_addr;
                                r_pf_valid <= 1'b1;
                            end else begin
                                r_din  <= bus.mem_dout;
                                r_wait <= 1'b0;
                            end
                        end else if (w_tmo) begin
                            r_err <= 1'b1;
                            if (!r_is_pf) begin
                                r_din  <= 8'hFF;
                                r_wait <= 1'b0;
                            end
                        end
                    end
                    PREFETCH: begin
                        r_pf_valid <= 1'b0;
                        if (w_pf_ok) begin
                            r_mem_addr <= w_inc;
                            r_is_pf    <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cart_upload_reader.sv
// tb_cart_upload_reader: directed reads against an SDRAM latency model; byte responses and SDRAM
// read addresses are checked through expected-value queues filled at stimulus time.
module tb_cart_upload_reader;
    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    int   total   = 0;
    int   bad     = 0;
    int   lat     = 6;
    int   waited  = 0;
    logic mon_busy = 1'b0;
    logic [31:0] rsp_q[$];
    logic [31:0] mem_q[$];
    logic [18:0] mem_a;
    event mem_ev;

    cart_upload_reader_if #(.ADDR_W(19)) bus();

    cart_upload_reader #(.ADDR_W(19), .TIMEOUT(255)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] mdata(input logic [18:0] a);
        case (a)
            19'h10:  mdata = 8'hA5;
            19'h11:  mdata = 8'h3C;
            default: mdata = a[7:0] ^ 8'h5A;
        endcase
    endfunction

    task automatic rd(input logic [24:0] a);
        @(posedge clk_sys); #2;
        bus.ioctl_rd   = 1'b1;
        bus.ioctl_addr = a;
        @(posedge clk_sys); #2;
        bus.ioctl_rd   = 1'b0;
    endtask

    task automatic wait_rsp;
        for (int i = 0; i < 500 && rsp_q.size() != 0; i++) @(negedge clk_sys);
        chk("rsp_drain", 32'(rsp_q.size()), 0);
    endtask

    task automatic settle;
        wait_rsp();
        repeat (14) @(posedge clk_sys);
        #2;
    endtask

    // response monitor: a read accepted while wait is low completes when wait is low afterwards
    initial begin
        forever begin
            @(negedge clk_sys);
            if (reset || !bus.ioctl_upload) mon_busy = 1'b0;
            else if (mon_busy) begin
                waited++;
                if (!bus.ioctl_wait) begin
                    mon_busy = 1'b0;
                    if (rsp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL din_unexpected: got %0h want none", bus.ioctl_din);
                    end else chk("din", 32'(bus.ioctl_din), rsp_q.pop_front());
                end else if (waited > 400) begin
                    mon_busy = 1'b0;
                    total++; bad++;
                    $display("FAIL rsp_timeout: got wait=1 want wait=0");
                    if (rsp_q.size() != 0) void'(rsp_q.pop_front());
                end
            end
            if (!mon_busy && !reset && bus.ioctl_upload && bus.ioctl_rd && bus.active && !bus.ioctl_wait) begin
                mon_busy = 1'b1;
                waited   = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_sys);
            if (bus.mem_rd) begin
                if (mem_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL mem_rd_unexpected: got addr %0h want none", bus.mem_addr);
                end else chk("mem_addr", 32'(bus.mem_addr), mem_q.pop_front());
                mem_a = bus.mem_addr;
                -> mem_ev;
            end
        end
    end

    // SDRAM model: busy rises the cycle after mem_rd, data valid when it falls
    initial begin
        logic [18:0] a;
        bus.mem_busy = 1'b0;
        bus.mem_dout = 8'h00;
        forever begin
            @(mem_ev);
            a = mem_a;
            @(posedge clk_sys); #2;
            bus.mem_busy = 1'b1;
            bus.mem_dout = 8'h00;
            repeat (lat) @(posedge clk_sys);
            #2;
            bus.mem_busy = 1'b0;
            bus.mem_dout = mdata(a);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ioctl_upload = 1'b0;
        bus.ioctl_rd     = 1'b0;
        bus.ioctl_addr   = '0;
        bus.rom_mask     = '0;
        repeat (3) @(negedge clk_sys);
        chk("rst_din",    32'(bus.ioctl_din), 32'hFF);
        chk("rst_wait",   32'(bus.ioctl_wait), 0);
        chk("rst_maddr",  32'(bus.mem_addr), 0);
        chk("rst_mrd",    32'(bus.mem_rd), 0);
        chk("rst_active", 32'(bus.active), 0);
        chk("rst_err",    32'(bus.timeout_err), 0);
        @(posedge clk_sys); #2;
        reset = 1'b0;
        bus.rom_mask     = 19'h3FF;
        bus.ioctl_upload = 1'b1;
        repeat (2) @(negedge clk_sys);
        chk("active_on", 32'(bus.active), 1);

        // miss at 0x10 followed by prefetch of 0x11
        mem_q.push_back(32'h10); mem_q.push_back(32'h11);
        rsp_q.push_back(32'hA5);
        rd(25'h10);
        @(negedge clk_sys);
        chk("miss_wait", 32'(bus.ioctl_wait), 1);
        settle();
        chk("miss_memq", 32'(mem_q.size()), 0);

        // prefetch hit at 0x11
        mem_q.push_back(32'h12);
        rsp_q.push_back(32'h3C);
        rd(25'h11);
        @(negedge clk_sys);
        chk("hit_wait", 32'(bus.ioctl_wait), 0);
        settle();
        chk("hit_memq", 32'(mem_q.size()), 0);

        // prefetch left at 0x21, then a non-sequential read; a strobe while waiting is ignored
        mem_q.push_back(32'h20); mem_q.push_back(32'h21);
        rsp_q.push_back(32'h7A);
        rd(25'h20);
        settle();
        mem_q.push_back(32'h80); mem_q.push_back(32'h81);
        rsp_q.push_back(32'hDA);
        rd(25'h80);
        @(negedge clk_sys);
        chk("nonseq_wait", 32'(bus.ioctl_wait), 1);
        rd(25'h99);
        settle();
        chk("nonseq_memq", 32'(mem_q.size()), 0);

        // bounds: beyond mask, then the last byte with no prefetch
        @(posedge clk_sys); #2;
        bus.rom_mask = 19'h0FF;
        rsp_q.push_back(32'hFF);
        rd(25'h100);
        @(negedge clk_sys);
        chk("oob_wait", 32'(bus.ioctl_wait), 0);
        settle();
        mem_q.push_back(32'hFF);
        rsp_q.push_back(32'hA5);
        rd(25'hFF);
        settle();
        chk("last_memq", 32'(mem_q.size()), 0);

        // top of address space: prefetch must not wrap to 0
        bus.rom_mask = 19'h7FFFF;
        mem_q.push_back(32'h7FFFF);
        rsp_q.push_back(32'hA5);
        rd(25'h1F7FFFF);
        settle();
        chk("wrap_memq", 32'(mem_q.size()), 0);

        // reads arriving during prefetches: one hits, one misses
        bus.rom_mask = 19'h3FF;
        mem_q.push_back(32'h40); mem_q.push_back(32'h41);
        mem_q.push_back(32'h42); mem_q.push_back(32'h50); mem_q.push_back(32'h51);
        rsp_q.push_back(32'h1A);
        rd(25'h40);
        wait_rsp();
        rsp_q.push_back(32'h1B);
        rd(25'h41);
        @(negedge clk_sys);
        chk("pend_wait", 32'(bus.ioctl_wait), 1);
        wait_rsp();
        rsp_q.push_back(32'h0A);
        rd(25'h50);
        settle();
        chk("pend_memq", 32'(mem_q.size()), 0);

        // reads with no session are ignored
        bus.ioctl_upload = 1'b0;
        repeat (3) @(posedge clk_sys);
        rd(25'h10);
        repeat (3) @(negedge clk_sys);
        chk("inactive_din",  32'(bus.ioctl_din), 32'h0A);
        chk("inactive_wait", 32'(bus.ioctl_wait), 0);
        @(posedge clk_sys); #2;
        bus.ioctl_upload = 1'b1;
        repeat (3) @(posedge clk_sys);

        // session dropped mid-WAIT
        mem_q.push_back(32'h30);
        rd(25'h30);
        @(negedge clk_sys);
        chk("abort_wait1", 32'(bus.ioctl_wait), 1);
        @(posedge clk_sys); #2;
        bus.ioctl_upload = 1'b0;
        @(posedge clk_sys);
        @(negedge clk_sys);
        chk("abort_wait0", 32'(bus.ioctl_wait), 0);
        repeat (20) @(posedge clk_sys);
        chk("abort_memq",   32'(mem_q.size()), 0);
        chk("abort_active", 32'(bus.active), 0);
        #2;
        bus.ioctl_upload = 1'b1;
        repeat (3) @(posedge clk_sys);

        // demand read timeout
        lat = 300;
        mem_q.push_back(32'h60);
        rsp_q.push_back(32'hFF);
        rd(25'h60);
        repeat (200) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("tmo_wait_held", 32'(bus.ioctl_wait), 1);
        chk("tmo_err_early", 32'(bus.timeout_err), 0);
        wait_rsp();
        chk("tmo_err",  32'(bus.timeout_err), 1);
        chk("tmo_wait", 32'(bus.ioctl_wait), 0);
        repeat (60) @(posedge clk_sys);
        chk("tmo_memq", 32'(mem_q.size()), 0);
        lat = 6;
        #2;
        bus.ioctl_upload = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("tmo_err_sticky", 32'(bus.timeout_err), 1);
        @(posedge clk_sys); #2;
        bus.ioctl_upload = 1'b1;
        repeat (3) @(negedge clk_sys);
        chk("tmo_err_clear", 32'(bus.timeout_err), 0);

        // asynchronous reset mid-read
        mem_q.push_back(32'h31);
        rd(25'h31);
        repeat (2) @(posedge clk_sys);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_din",    32'(bus.ioctl_din), 32'hFF);
        chk("arst_wait",   32'(bus.ioctl_wait), 0);
        chk("arst_maddr",  32'(bus.mem_addr), 0);
        chk("arst_mrd",    32'(bus.mem_rd), 0);
        chk("arst_active", 32'(bus.active), 0);
        chk("arst_err",    32'(bus.timeout_err), 0);
        @(posedge clk_sys); #2;
        reset = 1'b0;
        repeat (20) @(posedge clk_sys);

        // recovery after reset
        mem_q.push_back(32'h10); mem_q.push_back(32'h11);
        rsp_q.push_back(32'hA5);
        rd(25'h10);
        settle();
        chk("final_memq", 32'(mem_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
